hilo_muldiv_unit: RTL



---
 rtl/hilo_muldiv_unit_if.sv | 34 +++
 rtl/hilo_muldiv_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Bundle between the control/ALU side and the HI/LO unit.
//   Start/Op      : operation request with its opcode
//   busA/busB     : dividend (or mthi/mtlo source) and divisor
//   AluHi/AluLo   : ALU product high/low words for mult-capture
//   Busy/Done     : divide in progress / one-cycle divide-complete pulse
//   Hi/Lo         : HI and LO register contents
//   state_dbg     : current FSM state, for checkers
// Handshake: a request is Start=1 sampled on a rising clk edge. It is
// accepted only if Busy=0 at that edge; a request while Busy=1 is dropped,
// not queued. For a divide, Done=1 marks the single cycle in which the
// new Hi/Lo values are first visible, and Busy is already low then.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic [WIDTH-1:0] AluHi;
  logic [WIDTH-1:0] AluLo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic [1:0]       state_dbg;

  modport master (
    output Start, Op, busA, busB, AluHi, AluLo,
    input  Busy, Done, Hi, Lo, state_dbg
  );

  modport slave (
    input  Start, Op, busA, busB, AluHi, AluLo,
    output Busy, Done, Hi, Lo, state_dbg
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register unit: captures the ALU multiply result, implements
// mthi/mtlo, and runs a WIDTH-iteration restoring divider for div/divu.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset; aborts any divide in flight
//   bus   : request/status bundle (see hilo_muldiv_unit_if)
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  hilo_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, FIX = 2'd2} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;

  logic             start_div;
  logic             is_signed;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign start_div = bus.Start && (bus.Op == OP_DIV || bus.Op == OP_DIVU);
  assign is_signed = (bus.Op == OP_DIV);
  // Signed divide works on magnitudes; signs are reapplied in FIX.
  assign a_abs = (is_signed && bus.busA[WIDTH-1]) ? -bus.busA : bus.busA;
  assign b_abs = (is_signed && bus.busB[WIDTH-1]) ? -bus.busB : bus.busB;

  // Restoring step: bring the next dividend bit into the partial remainder
  // and keep the subtraction only if it does not go negative.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign take     = (shifted >= {1'b0, divisor});
  assign rem_next = take ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];

  assign q_fix = q_neg ? -quo : quo;
  assign r_fix = r_neg ? -rem : rem;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_div) state_next = DIV;
      DIV:     if (count == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            case (bus.Op)
              OP_MULT: begin
                hi <= bus.AluHi;
                lo <= bus.AluLo;
              end
              OP_MTHI: hi <= bus.busA;
              OP_MTLO: lo <= bus.busA;
              OP_DIV, OP_DIVU: begin
                rem      <= '0;
                quo      <= a_abs;
                divisor  <= b_abs;
                q_neg    <= is_signed && (bus.busA[WIDTH-1] ^ bus.busB[WIDTH-1]);
                r_neg    <= is_signed && bus.busA[WIDTH-1];
                div_zero <= (bus.busB == '0);
                count    <= CW'(WIDTH);
              end
              default: ;
            endcase
          end
        end
        DIV: begin
          rem   <= rem_next;
          quo   <= {quo[WIDTH-2:0], take};
          count <= count - CW'(1);
        end
        FIX: begin
          // With a zero divisor the remainder already equals the dividend
          // (sign restored by r_fix); only the quotient needs forcing.
          lo   <= div_zero ? '1 : q_fix;
          hi   <= r_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = done;
  assign bus.Hi        = hi;
  assign bus.Lo        = lo;
  assign bus.state_dbg = state;
endmodule
